// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux select arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } arb_state_t;

    localparam logic        SEL_A        = 1'b1;
    localparam logic        SEL_B        = 1'b0;
    localparam int unsigned HOLD_MAX_DEF = 32'd4;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Saturating hold counter: counts cycles of the current grant.
// Stops at HOLD_MAX-1 and flags expiry.
module mux_arb_hold_cnt
    import mux_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
    parameter int unsigned CNT_W    = 32'd8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_MAX - 32'd1);

    logic [CNT_W-1:0] count_r;

    // Clear wins over enable; the count holds once it reaches LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && (count_r != LAST)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter with bounded hold driving the 2:1 mux select.
// Optional MUX_SEL_LOCK_EN adds lock_i, which suspends the hold timeout.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
    parameter int unsigned CNT_W    = 32'd8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_a_i,
    input  logic req_b_i,
`ifdef MUX_SEL_LOCK_EN
    input  logic lock_i,
`endif
    output logic gnt_a_o,
    output logic gnt_b_o,
    output logic s_o,
    output logic busy_o
);

    arb_state_t state_r;
    arb_state_t state_s;
    logic       ptr_a_r;
    logic       ptr_a_s;
    logic       cnt_clr_s;
    logic       cnt_en_s;
    logic       expired_s;
    logic       lock_s;
    logic       gnt_a_r;
    logic       gnt_b_r;
    logic       sel_r;
    logic       busy_r;

`ifdef MUX_SEL_LOCK_EN
    assign lock_s = lock_i;
`else
    assign lock_s = 1'b0;
`endif

    mux_arb_hold_cnt #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) u_hold_cnt (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .expired (expired_s)
    );

    // Next-state, pointer and counter control; ptr_a = 1 means A wins the next tie.
    always_comb begin
        state_s   = state_r;
        ptr_a_s   = ptr_a_r;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_clr_s = 1'b1;
                if (req_a_i && (!req_b_i || ptr_a_r)) begin
                    state_s = GRANT_A;
                    ptr_a_s = 1'b0;
                end else if (req_b_i) begin
                    state_s = GRANT_B;
                    ptr_a_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT_A: begin
                if (!req_a_i || (expired_s && req_b_i && !lock_s)) begin
                    cnt_clr_s = 1'b1;
                    if (req_b_i) begin
                        state_s = GRANT_B;
                        ptr_a_s = 1'b1;
                    end else if (req_a_i) begin
                        state_s = GRANT_A;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_en_s = !lock_s;
                end
            end
            GRANT_B: begin
                if (!req_b_i || (expired_s && req_a_i && !lock_s)) begin
                    cnt_clr_s = 1'b1;
                    if (req_a_i) begin
                        state_s = GRANT_A;
                        ptr_a_s = 1'b0;
                    end else if (req_b_i) begin
                        state_s = GRANT_B;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_en_s = !lock_s;
                end
            end
            default: begin
                state_s   = IDLE;
                ptr_a_s   = 1'b1;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // State and priority pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            ptr_a_r <= 1'b1;
        end else begin
            state_r <= state_s;
            ptr_a_r <= ptr_a_s;
        end
    end

    // Outputs loaded from the next state; select only moves on grant entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_a_r <= 1'b0;
            gnt_b_r <= 1'b0;
            busy_r  <= 1'b0;
            sel_r   <= 1'b0;
        end else begin
            gnt_a_r <= (state_s == GRANT_A);
            gnt_b_r <= (state_s == GRANT_B);
            busy_r  <= (state_s != IDLE);
            if (state_s == GRANT_A) begin
                sel_r <= SEL_A;
            end else if (state_s == GRANT_B) begin
                sel_r <= SEL_B;
            end else begin
                sel_r <= sel_r;
            end
        end
    end

    assign gnt_a_o = gnt_a_r;
    assign gnt_b_o = gnt_b_r;
    assign s_o     = sel_r;
    assign busy_o  = busy_r;

endmodule
